uc_multiciclo: RTL

Parametrised multicycle control unit for the RV64 datapath. It sequences fetch, decode, execute, memory and writeback for add/sub/and/addi/ld/sd/beq/bne/lui/jal. It tolerates memories with a configurable read latency, traps unsupported encodings, and counts retired instructions. It drives every strobe and mux select of the datapath top and reads back IR fields and ALU flags.

---
 rtl/uc_pkg.sv | 75 +++++++
 rtl/uc_decode.sv | 43 ++++
 rtl/uc_multiciclo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// Purpose: shared types and encodings for the multicycle control unit.
// Latency: none (definitions only).
// Backpressure: none.
package uc_pkg;

  // FSM states; FETCH is encoded as zero so the gated debug output and the
  // post-reset state read the same.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_LUI    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // funct3 values (IR[14:12])
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ALU_SELECTOR codes
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // ALU_SRCA
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_A      = 2'b01;
  localparam logic [1:0] SRCA_PC_OLD = 2'b10;

  // ALU_SRCB
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC_SRC
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // MEM_TO_REG
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_IMM    = 2'b11;

  // States whose exit completes (retires) an instruction.
  function automatic logic is_final(state_t s);
    case (s)
      S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JAL, S_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Purpose: map opcode/funct fields to the state following DECODE and the R-type ALU op.
// Latency: purely combinational.
// Backpressure: none; fields are held stable by the instruction register.
module uc_decode
  import uc_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output state_t     o_next_state,
  output logic [2:0] o_alu_op
);

  // Anything not explicitly recognised falls through to TRAP.
  always_comb begin
    o_next_state = S_TRAP;
    o_alu_op     = ALU_ADD;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_funct3 == F3_ADD) begin
          o_next_state = S_EXEC_R;
          o_alu_op     = i_funct7_5 ? ALU_SUB : ALU_ADD;
        end else if (i_funct3 == F3_AND && !i_funct7_5) begin
          o_next_state = S_EXEC_R;
          o_alu_op     = ALU_AND;
        end
      end
      OP_IMM: begin
        if (i_funct3 == F3_ADD) o_next_state = S_EXEC_I;
      end
      OP_LOAD, OP_STORE: begin
        if (i_funct3 == F3_DW) o_next_state = S_ADDR;
      end
      OP_BRANCH: begin
        if (i_funct3 == F3_BEQ || i_funct3 == F3_BNE) o_next_state = S_BRANCH;
      end
      OP_JAL:  o_next_state = S_JAL;
      OP_LUI:  o_next_state = S_LUI;
      default: o_next_state = S_TRAP;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Purpose: multicycle control FSM for the RV64 datapath (fetch/decode/exec/mem/wb, trap, retire count).
// Latency: R/addi/sd L+3, ld 2L+3, beq/bne/jal/lui L+2 cycles, L = MEM_LATENCY.
// Backpressure: none; memory is assumed ready after a fixed MEM_LATENCY wait.
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int MEM_LATENCY = 2,  // 1..15, bounded by the 4-bit wait counter
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [6:0]           IR6_0,
  input  logic [2:0]           FUNCT3,
  input  logic                 FUNCT7_5,
  input  logic                 ZERO,
  output logic                 PC_WRITE,
  output logic                 IR_WRITE,
  output logic                 LOAD_A,
  output logic                 LOAD_B,
  output logic                 LOAD_ALUOUT,
  output logic                 LOAD_MDR,
  output logic                 BANCO_WRITE,
  output logic                 MEM32_WR,
  output logic                 MEM64_WR,
  output logic [1:0]           ALU_SRCA,
  output logic [1:0]           ALU_SRCB,
  output logic [2:0]           ALU_SELECTOR,
  output logic [1:0]           PC_SRC,
  output logic [1:0]           MEM_TO_REG,
  output logic                 ILLEGAL,
  output logic [3:0]           STATE,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  localparam logic [3:0] WLAST = 4'(MEM_LATENCY - 1);

  state_t                 r_state;
  logic [3:0]             r_wcnt;
  logic                   r_illegal;
  logic [CNT_WIDTH-1:0]   r_retired;

  state_t                 w_dec_next;
  logic [2:0]             w_dec_alu_op;
  logic                   w_wlast;

  logic                   w_pc_write, w_ir_write, w_load_a, w_load_b, w_load_aluout;
  logic                   w_load_mdr, w_banco_write, w_mem64_wr;
  logic [1:0]             w_srca, w_srcb, w_pc_src, w_m2r;
  logic [2:0]             w_alu_sel;

  uc_decode u_decode (
    .i_opcode     (IR6_0),
    .i_funct3     (FUNCT3),
    .i_funct7_5   (FUNCT7_5),
    .o_next_state (w_dec_next),
    .o_alu_op     (w_dec_alu_op)
  );

  assign w_wlast = (r_wcnt == WLAST);

  // State sequencing, memory wait counter, sticky trap flag and retire counter.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= S_FETCH;
      r_wcnt    <= 4'd0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_wlast) begin
            r_wcnt  <= 4'd0;
            r_state <= S_DECODE;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        S_DECODE: begin
          r_state <= w_dec_next;
          if (w_dec_next == S_TRAP) r_illegal <= 1'b1;
        end
        S_EXEC_R, S_EXEC_I: r_state <= S_WB_ALU;
        S_ADDR: begin
          // IR is still held, so the opcode tells load from store here.
          r_wcnt  <= 4'd0;
          r_state <= (IR6_0 == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          if (w_wlast) begin
            r_wcnt  <= 4'd0;
            r_state <= S_WB_MEM;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        S_TRAP: r_state <= S_TRAP;
        default: begin
          r_wcnt  <= 4'd0;
          r_state <= S_FETCH;
          if (is_final(r_state)) r_retired <= r_retired + CNT_WIDTH'(1);
        end
      endcase
    end
  end

  // Moore output decode; only the branch PC write looks at a live input (ZERO).
  always_comb begin
    w_pc_write    = 1'b0;
    w_ir_write    = 1'b0;
    w_load_a      = 1'b0;
    w_load_b      = 1'b0;
    w_load_aluout = 1'b0;
    w_load_mdr    = 1'b0;
    w_banco_write = 1'b0;
    w_mem64_wr    = 1'b0;
    w_srca        = SRCA_PC;
    w_srcb        = SRCB_B;
    w_alu_sel     = ALU_PASS;
    w_pc_src      = PCSRC_ALU;
    w_m2r         = M2R_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_srca     = SRCA_PC;
        w_srcb     = SRCB_FOUR;
        w_alu_sel  = ALU_ADD;
        w_pc_src   = PCSRC_ALU;
        w_ir_write = w_wlast;
        w_pc_write = w_wlast;
      end
      S_DECODE: begin
        // Branch/jal target is computed speculatively and parked in ALUOut.
        w_load_a      = 1'b1;
        w_load_b      = 1'b1;
        w_load_aluout = 1'b1;
        w_srca        = SRCA_PC_OLD;
        w_srcb        = SRCB_IMM_SH;
        w_alu_sel     = ALU_ADD;
      end
      S_EXEC_R: begin
        w_srca        = SRCA_A;
        w_srcb        = SRCB_B;
        w_alu_sel     = w_dec_alu_op;
        w_load_aluout = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        w_srca        = SRCA_A;
        w_srcb        = SRCB_IMM;
        w_alu_sel     = ALU_ADD;
        w_load_aluout = 1'b1;
      end
      S_MEM_RD: w_load_mdr = w_wlast;
      S_MEM_WR: w_mem64_wr = 1'b1;
      S_WB_ALU: begin
        w_banco_write = 1'b1;
        w_m2r         = M2R_ALUOUT;
      end
      S_WB_MEM: begin
        w_banco_write = 1'b1;
        w_m2r         = M2R_MDR;
      end
      S_BRANCH: begin
        w_srca     = SRCA_A;
        w_srcb     = SRCB_B;
        w_alu_sel  = ALU_SUB;
        w_pc_src   = PCSRC_ALUOUT;
        w_pc_write = (FUNCT3 == F3_BNE) ? ~ZERO : ZERO;
      end
      S_JAL: begin
        w_banco_write = 1'b1;
        w_m2r         = M2R_PC;
        w_pc_write    = 1'b1;
        w_pc_src      = PCSRC_ALUOUT;
      end
      S_LUI: begin
        w_banco_write = 1'b1;
        w_m2r         = M2R_IMM;
      end
      default: ;
    endcase
  end

  // Everything reads zero while RESET is held low, whatever the state register holds.
  assign PC_WRITE     = RESET & w_pc_write;
  assign IR_WRITE     = RESET & w_ir_write;
  assign LOAD_A       = RESET & w_load_a;
  assign LOAD_B       = RESET & w_load_b;
  assign LOAD_ALUOUT  = RESET & w_load_aluout;
  assign LOAD_MDR     = RESET & w_load_mdr;
  assign BANCO_WRITE  = RESET & w_banco_write;
  assign MEM32_WR     = 1'b0;
  assign MEM64_WR     = RESET & w_mem64_wr;
  assign ALU_SRCA     = RESET ? w_srca : 2'b00;
  assign ALU_SRCB     = RESET ? w_srcb : 2'b00;
  assign ALU_SELECTOR = RESET ? w_alu_sel : 3'b000;
  assign PC_SRC       = RESET ? w_pc_src : 2'b00;
  assign MEM_TO_REG   = RESET ? w_m2r : 2'b00;
  assign ILLEGAL      = RESET & r_illegal;
  assign STATE        = RESET ? r_state : 4'd0;
  assign RETIRED      = RESET ? r_retired : '0;

endmodule
